// File: rtl/z80_sys_pkg.sv
// rtl/z80_sys_pkg.sv - shared constants and arbiter state encoding for the Z80 memory subsystem
package z80_sys_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_ISS,
    ST_CPU_CAP,
    ST_DMA_ISS,
    ST_DMA_CAP
  } arb_state_t;

endpackage

// File: rtl/z80_bus_req_latch.sv
// rtl/z80_bus_req_latch.sv - Z80 strobe edge detector and single-entry request latch
module z80_bus_req_latch
  import z80_sys_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        clear,
  output logic        rise,
  output logic        pend,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  output logic        req_we
);

  logic        sel;
  logic        sel_d;
  logic        live_we;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        lat_we;

  assign sel     = !cpu_mreq_n && cpu_rfsh_n && (!cpu_rd_n || !cpu_wr_n);
  assign live_we = !cpu_wr_n ? DIR_WRITE : DIR_READ;
  // A second rise while an access is still pending is dropped.
  assign rise    = sel && !sel_d && !pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_d     <= 1'b0;
      pend      <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= DIR_READ;
    end else begin
      sel_d <= sel;
      if (rise) begin
        pend      <= 1'b1;
        lat_addr  <= cpu_a;
        lat_wdata <= cpu_dout;
        lat_we    <= live_we;
      end else if (clear) begin
        pend <= 1'b0;
      end
    end
  end

  // Bypass lets the arbiter grant in the same cycle the rise is seen.
  assign req_addr  = rise ? cpu_a    : lat_addr;
  assign req_wdata = rise ? cpu_dout : lat_wdata;
  assign req_we    = rise ? live_we  : lat_we;

endmodule

// File: rtl/z80_mem_arbiter.sv
// rtl/z80_mem_arbiter.sv - CPU/DMA arbiter for a single-port synchronous RAM with DMA starvation guard
module z80_mem_arbiter
  import z80_sys_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic        cpu_rise;
  logic        cpu_pend;
  logic        cpu_req_we;
  logic [15:0] cpu_req_addr;
  logic [7:0]  cpu_req_wdata;
  logic        cpu_done;
  logic [2:0]  starve_cnt;
  logic        dma_wait;
  logic        grant_cpu;
  logic        grant_dma;

  z80_bus_req_latch u_req_latch (
    .clk        (clk),
    .reset      (reset),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .clear      (state == ST_CPU_CAP),
    .rise       (cpu_rise),
    .pend       (cpu_pend),
    .req_addr   (cpu_req_addr),
    .req_wdata  (cpu_req_wdata),
    .req_we     (cpu_req_we)
  );

  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    // dma_req is still high in its ack cycle; that must not count as a new request.
    dma_wait  = dma_req && !dma_ack && (state != ST_DMA_ISS) && (state != ST_DMA_CAP);
    unique case (state)
      ST_IDLE: begin
        if ((cpu_pend || cpu_rise) && !(dma_wait && starve_cnt == LIMIT)) begin
          grant_cpu = 1'b1;
          state_nxt = ST_CPU_ISS;
        end else if (dma_wait) begin
          grant_dma = 1'b1;
          state_nxt = ST_DMA_ISS;
        end
      end
      ST_CPU_ISS: state_nxt = ST_CPU_CAP;
      ST_CPU_CAP: state_nxt = ST_IDLE;
      ST_DMA_ISS: state_nxt = ST_DMA_CAP;
      ST_DMA_CAP: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      cpu_done   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_wait_n <= 1'b1;
      cpu_di     <= '0;
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      dma_ack  <= 1'b0;
      cpu_done <= (state == ST_CPU_CAP);

      if (!dma_wait || grant_dma)
        starve_cnt <= '0;
      else if (grant_cpu && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 3'd1;

      if (grant_cpu) begin
        mem_en    <= 1'b1;
        mem_we    <= cpu_req_we;
        mem_addr  <= cpu_req_addr;
        mem_wdata <= cpu_req_wdata;
      end else if (grant_dma) begin
        mem_en    <= 1'b1;
        mem_we    <= dma_we;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
      end

      if (state == ST_CPU_CAP && cpu_req_we == DIR_READ)
        cpu_di <= mem_rdata;

      if (state == ST_DMA_CAP) begin
        dma_ack <= 1'b1;
        if (dma_we == DIR_READ)
          dma_rdata <= mem_rdata;
      end

      // Wait is released one cycle after the captured data is on cpu_di.
      if (cpu_rise)
        cpu_wait_n <= 1'b0;
      else if (cpu_done)
        cpu_wait_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// tb/tb_z80_mem_arbiter.sv - directed self-checking bench for z80_mem_arbiter
module tb_z80_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  ram [0:65535];

  int total = 0;
  int bad   = 0;

  z80_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_di     (cpu_di),
    .cpu_wait_n (cpu_wait_n),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model with a preload port used while the DUT is in reset.
  always @(posedge clk) begin
    if (pl_en)
      ram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we)
        ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_put(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic strobes_off();
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic cpu_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           output int lo, output int ens, output logic [15:0] ea,
                           output logic ewe, output logic [7:0] ed);
    cpu_a = a; cpu_dout = d; cpu_mreq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = !wr;
    lo = 0; ens = 0; ea = '0; ewe = 1'b0; ed = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_en) begin ens++; ea = mem_addr; ewe = mem_we; ed = mem_wdata; end
      if (!cpu_wait_n) lo++;
      else if (lo > 0) break;
    end
    strobes_off();
  endtask

  int          lo, ens, lat, hi_at, ack_at, n_en, nev, ack_seen, cnt_max;
  logic [15:0] ea, first_addr, second_addr;
  logic        ewe;
  logic [7:0]  ed, di3, rdat;
  logic [2:0]  cnt_at_ack;
  logic [15:0] ev [0:7];

  task automatic starve_sample();
    step();
    if (mem_en && nev < 8) begin ev[nev] = mem_addr; nev++; end
    if (int'(dut.starve_cnt) > cnt_max) cnt_max = int'(dut.starve_cnt);
    if (dma_ack) begin ack_seen++; cnt_at_ack = dut.starve_cnt; dma_req = 1'b0; end
  endtask

  initial begin
    reset = 1'b1;
    strobes_off();
    cpu_rfsh_n = 1'b1; cpu_a = '0; cpu_dout = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    step(); step();
    ram_put(16'h1234, 8'hA5);
    ram_put(16'h0010, 8'h3C);
    ram_put(16'h2000, 8'h77);
    ram_put(16'h0011, 8'h99);
    for (int k = 0; k < 5; k++) ram_put(16'h3000 + 16'(k), 8'h10 + 8'(k));

    chk_eq("rst_mem_en",    mem_en,     0);
    chk_eq("rst_mem_we",    mem_we,     0);
    chk_eq("rst_mem_addr",  mem_addr,   0);
    chk_eq("rst_mem_wdata", mem_wdata,  0);
    chk_eq("rst_wait_n",    cpu_wait_n, 1);
    chk_eq("rst_cpu_di",    cpu_di,     0);
    chk_eq("rst_dma_ack",   dma_ack,    0);
    chk_eq("rst_dma_rdata", dma_rdata,  0);
    reset = 1'b0;
    step();

    // CPU read 0x1234
    cpu_cycle(1'b0, 16'h1234, 8'h00, lo, ens, ea, ewe, ed);
    chk_eq("rd_wait_lo", lo, 3);
    chk_eq("rd_en_cnt",  ens, 1);
    chk_eq("rd_addr",    ea, 16'h1234);
    chk_eq("rd_we",      ewe, 0);
    chk_eq("rd_cpu_di",  cpu_di, 8'hA5);
    step();

    // CPU write 0x5A to 0x8000
    cpu_cycle(1'b1, 16'h8000, 8'h5A, lo, ens, ea, ewe, ed);
    chk_eq("wr_wait_lo", lo, 3);
    chk_eq("wr_en_cnt",  ens, 1);
    chk_eq("wr_addr",    ea, 16'h8000);
    chk_eq("wr_we",      ewe, 1);
    chk_eq("wr_wdata",   ed, 8'h5A);
    chk_eq("wr_cpu_di_held", cpu_di, 8'hA5);
    chk_eq("wr_ram",     ram[16'h8000], 8'h5A);
    step();

    // DMA read 0x0010 with the CPU idle
    dma_addr = 16'h0010; dma_we = 1'b0; dma_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (dma_ack) begin lat = i; break; end
    end
    chk_eq("dma_latency", lat, 3);
    chk_eq("dma_rdata",   dma_rdata, 8'h3C);
    dma_req = 1'b0;
    step();
    chk_eq("dma_ack_pulse", dma_ack, 0);
    step();

    // CPU rise and DMA request in the same cycle
    cpu_a = 16'h2000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    dma_addr = 16'h0011; dma_we = 1'b0; dma_req = 1'b1;
    lo = 0; n_en = 0; hi_at = 0; ack_at = 0; di3 = '0; rdat = '0;
    first_addr = '0; second_addr = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (mem_en) begin
        if (n_en == 0) first_addr = mem_addr; else second_addr = mem_addr;
        n_en++;
      end
      if (!cpu_wait_n) lo++;
      else if (lo > 0 && hi_at == 0) begin hi_at = i; strobes_off(); end
      if (i == 3) di3 = cpu_di;
      if (dma_ack) begin ack_at = i; rdat = dma_rdata; dma_req = 1'b0; break; end
    end
    strobes_off();
    chk_eq("race_first_addr",  first_addr, 16'h2000);
    chk_eq("race_second_addr", second_addr, 16'h0011);
    chk_eq("race_wait_lo",     lo, 3);
    chk_eq("race_wait_hi_at",  hi_at, 4);
    chk_eq("race_cpu_di",      di3, 8'h77);
    chk_eq("race_ack_at",      ack_at, 6);
    chk_eq("race_dma_rdata",   rdat, 8'h99);
    step(); step();

    // Back-to-back CPU reads while DMA waits: DMA must get in after 4 CPU grants
    nev = 0; ack_seen = 0; cnt_max = 0; cnt_at_ack = 3'd7;
    dma_addr = 16'h0020; dma_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cpu_a = 16'h3000 + 16'(k); cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
      if (k == 0) dma_req = 1'b1;
      starve_sample();
      strobes_off();
      starve_sample();
      starve_sample();
    end
    for (int i = 0; i < 12; i++) starve_sample();
    chk_eq("stv_n_access", nev, 6);
    chk_eq("stv_ev0", ev[0], 16'h3000);
    chk_eq("stv_ev1", ev[1], 16'h3001);
    chk_eq("stv_ev2", ev[2], 16'h3002);
    chk_eq("stv_ev3", ev[3], 16'h3003);
    chk_eq("stv_ev4", ev[4], 16'h0020);
    chk_eq("stv_ev5", ev[5], 16'h3004);
    chk_eq("stv_ack_count", ack_seen, 1);
    chk_eq("stv_cnt_max",   cnt_max, 4);
    chk_eq("stv_cnt_at_ack", cnt_at_ack, 0);
    chk_eq("stv_cnt_end",   dut.starve_cnt, 0);
    chk_eq("stv_cpu_di",    cpu_di, 8'h14);

    // Reset asserted while the CPU access is in its issue cycle
    cpu_a = 16'h1234; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    step();
    chk_eq("rstiss_mem_en", mem_en, 1);
    reset = 1'b1;
    strobes_off();
    step();
    chk_eq("rstiss_mem_en_off", mem_en, 0);
    chk_eq("rstiss_mem_addr",   mem_addr, 0);
    chk_eq("rstiss_wait_n",     cpu_wait_n, 1);
    chk_eq("rstiss_cpu_di",     cpu_di, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_eq("rstiss_cpu_di_late", cpu_di, 0);
    chk_eq("rstiss_wait_late",   cpu_wait_n, 1);
    chk_eq("rstiss_ack_late",    dma_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
